mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit bridging the memory pipeline stage to an external word-wide memory
//
// Purpose: accepts one load or store from the memory stage, checks alignment and
// size legality, issues a single word-aligned request with lane-shifted data and
// byte strobes, waits for read data on loads, extracts and extends the loaded
// value, and aborts any transaction that exceeds TIMEOUT_CYCLES in REQ plus WAIT.
//
// Ports:
//   i_clk, i_reset_n                 clock, asynchronous active-low reset
//   i_req_valid/wr/funct3/addr/wdata memory-stage access request
//   o_stall                          hold earlier pipeline stages
//   o_rd_data, o_rd_valid            extended load result and its one-cycle pulse
//   o_fault, o_timeout               one-cycle pulses: illegal access, aborted access
//   o_mem_valid/wr/addr/wdata/strb   request to external memory
//   i_mem_ready                      memory accepts the request
//   i_mem_rvalid, i_mem_rdata        read data return

module mem_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_req_valid,
    input  logic                      i_req_wr,
    input  logic [2:0]                i_req_funct3,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    input  logic [DATA_WIDTH-1:0]     i_req_wdata,
    output logic                      o_stall,
    output logic [DATA_WIDTH-1:0]     o_rd_data,
    output logic                      o_rd_valid,
    output logic                      o_fault,
    output logic                      o_timeout,
    output logic                      o_mem_valid,
    input  logic                      i_mem_ready,
    output logic                      o_mem_wr,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_mem_strb,
    input  logic                      i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int LW = $clog2(NB);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [2:0]      r_funct3;
    logic [LW-1:0]   r_lane;
    logic [15:0]     r_cnt;

    logic [LW-1:0]         w_lane;
    logic                  w_fault;
    logic [NB-1:0]         w_base_strb;
    logic [NB-1:0]         w_strb;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH-1:0] w_keep;
    logic                  w_sign_bit;
    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_expire;

    assign w_lane = i_req_addr[LW-1:0];

    // Misalignment and sizes the configured width cannot carry.
    always_comb begin
        w_fault = 1'b0;
        case (i_req_funct3)
            3'b000, 3'b100: w_fault = 1'b0;
            3'b001, 3'b101: w_fault = w_lane[0];
            3'b010:         w_fault = |w_lane[1:0];
            3'b110:         w_fault = (DATA_WIDTH == 32) || (|w_lane[1:0]);
            3'b011:         w_fault = (DATA_WIDTH == 32) || (|w_lane);
            default:        w_fault = 1'b1;
        endcase
    end

    always_comb begin
        w_base_strb = '0;
        case (i_req_funct3[1:0])
            2'b00:   w_base_strb = NB'(8'h01);
            2'b01:   w_base_strb = NB'(8'h03);
            2'b10:   w_base_strb = NB'(8'h0F);
            default: w_base_strb = NB'(8'hFF);
        endcase
    end

    assign w_strb  = i_req_wr ? (w_base_strb << w_lane) : '0;
    assign w_wdata = i_req_wdata << {w_lane, 3'b000};

    // Load extraction: keep the access size, then fill the upper bits with the
    // sign bit for signed sizes. A full-width load has nothing above to fill.
    assign w_shift = i_mem_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_keep     = '1;
        w_sign_bit = 1'b0;
        case (r_funct3[1:0])
            2'b00: begin
                w_keep     = DATA_WIDTH'(8'hFF);
                w_sign_bit = w_shift[7];
            end
            2'b01: begin
                w_keep     = DATA_WIDTH'(16'hFFFF);
                w_sign_bit = w_shift[15];
            end
            2'b10: begin
                w_keep     = DATA_WIDTH'(32'hFFFF_FFFF);
                w_sign_bit = w_shift[31];
            end
            default: begin
                w_keep     = '1;
                w_sign_bit = 1'b0;
            end
        endcase
    end

    assign w_load = (w_shift & w_keep) |
                    ((!r_funct3[2] && w_sign_bit) ? ~w_keep : '0);

    assign w_expire = (r_cnt >= TO_LAST);

    // Stall starts combinationally in the accepting cycle so the pipeline never
    // advances past an accepted access.
    assign o_stall = i_reset_n &&
                     ((r_state == S_REQ) || (r_state == S_WAIT) ||
                      ((r_state == S_IDLE) && i_req_valid && !w_fault));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_funct3    <= '0;
            r_lane      <= '0;
            r_cnt       <= '0;
            o_rd_data   <= '0;
            o_rd_valid  <= 1'b0;
            o_fault     <= 1'b0;
            o_timeout   <= 1'b0;
            o_mem_valid <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_strb  <= '0;
        end else begin
            o_rd_valid <= 1'b0;
            o_fault    <= 1'b0;
            o_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        if (w_fault) begin
                            o_fault <= 1'b1;
                        end else begin
                            r_funct3    <= i_req_funct3;
                            r_lane      <= w_lane;
                            r_cnt       <= '0;
                            o_mem_valid <= 1'b1;
                            o_mem_wr    <= i_req_wr;
                            o_mem_addr  <= {i_req_addr[ADDR_WIDTH-1:LW], {LW{1'b0}}};
                            o_mem_wdata <= w_wdata;
                            o_mem_strb  <= w_strb;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (i_mem_ready) begin
                        // The memory has taken the request; a load accepted on
                        // the final allowed cycle has no budget left to wait.
                        o_mem_valid <= 1'b0;
                        if (o_mem_wr) begin
                            r_state <= S_DONE;
                        end else if (w_expire) begin
                            o_timeout <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_expire) begin
                        o_mem_valid <= 1'b0;
                        o_timeout   <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (i_mem_rvalid) begin
                        o_rd_data  <= w_load;
                        o_rd_valid <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (w_expire) begin
                        o_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural access model

module tb_mem_access_unit;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;
    localparam int NB = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_req_valid;
    logic            i_req_wr;
    logic [2:0]      i_req_funct3;
    logic [AW-1:0]   i_req_addr;
    logic [DW-1:0]   i_req_wdata;
    logic            o_stall;
    logic [DW-1:0]   o_rd_data;
    logic            o_rd_valid;
    logic            o_fault;
    logic            o_timeout;
    logic            o_mem_valid;
    logic            i_mem_ready;
    logic            o_mem_wr;
    logic [AW-1:0]   o_mem_addr;
    logic [DW-1:0]   o_mem_wdata;
    logic [NB-1:0]   o_mem_strb;
    logic            i_mem_rvalid;
    logic [DW-1:0]   i_mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_req_valid(i_req_valid),
        .i_req_wr(i_req_wr),
        .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata),
        .o_stall(o_stall),
        .o_rd_data(o_rd_data),
        .o_rd_valid(o_rd_valid),
        .o_fault(o_fault),
        .o_timeout(o_timeout),
        .o_mem_valid(o_mem_valid),
        .i_mem_ready(i_mem_ready),
        .o_mem_wr(o_mem_wr),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_mem_strb(o_mem_strb),
        .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } mem_exp_t;

    mem_exp_t    q_mem[$];
    logic [31:0] q_rd[$];
    int          q_fault[$];
    logic [31:0] q_to[$];
    logic [31:0] held_rd;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every visible DUT event pops the matching expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_mem_valid && i_mem_ready) begin
                if (q_mem.size() == 0) begin
                    check("unexpected_mem_handshake", 1, 0);
                end else begin
                    mem_exp_t e;
                    e = q_mem.pop_front();
                    check("mem_addr", o_mem_addr, e.addr);
                    check("mem_wr", o_mem_wr, e.wr);
                    check("mem_strb", o_mem_strb, e.strb);
                    if (e.wr) check("mem_wdata", o_mem_wdata, e.wdata);
                end
            end
            if (o_rd_valid) begin
                if (q_rd.size() == 0) check("unexpected_rd_valid", 1, 0);
                else check("rd_data", o_rd_data, q_rd.pop_front());
                check("rd_valid_no_stall", o_stall, 0);
            end
            if (o_fault) begin
                if (q_fault.size() == 0) check("unexpected_fault", 1, 0);
                else check("fault_expected", q_fault.pop_front(), 1);
                check("fault_no_mem_valid", o_mem_valid, 0);
            end
            if (o_timeout) begin
                if (q_to.size() == 0) begin
                    check("unexpected_timeout", 1, 0);
                end else begin
                    check("timeout_rd_hold", o_rd_data, q_to.pop_front());
                end
                check("timeout_mem_valid_dropped", o_mem_valid, 0);
                check("timeout_no_rd_valid", o_rd_valid, 0);
            end
        end
    end

    // One instruction: reference expectations, then a cycle-accurate memory
    // response schedule. d_r = REQ cycles before ready, d_v = WAIT cycles before rvalid.
    task automatic do_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int d_r, input int d_v);
        int          size;
        bit          sgn;
        bit          flt;
        int          lane;
        int          fin;
        bit          ok;
        int          stall_cnt;
        logic [63:0] v;
        logic [63:0] mask;
        mem_exp_t    e;

        lane = addr % NB;
        flt  = 0;
        sgn  = 0;
        size = 1;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = 1; end
            3'd4: begin size = 1; sgn = 0; end
            3'd5: begin size = 2; sgn = 0; end
            default: flt = 1;
        endcase
        if (lane % size != 0) flt = 1;

        i_req_valid  = 1'b1;
        i_req_wr     = wr;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;

        if (flt) begin
            q_fault.push_back(1);
            @(negedge clk);
            check("fault_stall_low", o_stall, 0);
            @(posedge clk);
            #1;
            i_req_valid = 1'b0;
            return;
        end

        ok  = wr ? (d_r + 1 <= TO) : (d_r + d_v + 2 <= TO);
        fin = ok ? (wr ? d_r + 1 : d_r + d_v + 2) : TO;

        if (d_r + 1 <= TO) begin
            e.addr  = addr & ~32'(NB - 1);
            e.wr    = wr;
            v       = {32'h0, wdata} << (8 * lane);
            e.wdata = v[31:0];
            mask    = ((64'h1 << size) - 1) << lane;
            e.strb  = wr ? mask[3:0] : 4'h0;
            q_mem.push_back(e);
        end

        if (!ok) begin
            q_to.push_back(held_rd);
        end else if (!wr) begin
            v    = {32'h0, rdata} >> (8 * lane);
            mask = (64'h1 << (8 * size)) - 1;
            v    = v & mask;
            if (sgn && v[8 * size - 1]) v = v | ~mask;
            held_rd = v[31:0];
            q_rd.push_back(held_rd);
        end

        stall_cnt = 0;
        for (int c = 0; c <= fin + 1; c++) begin
            @(negedge clk);
            if (o_stall) stall_cnt++;
            @(posedge clk);
            #1;
            i_mem_ready = ((c + 1) == d_r + 1) && ((c + 1) <= fin);
            if (!wr && ((c + 1) == d_r + d_v + 2) && ((c + 1) <= fin)) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = rdata;
            end else if ((c + 1) <= d_r + 1 && (c + 1) <= fin) begin
                i_mem_rvalid = 1'($urandom % 2);
                i_mem_rdata  = $urandom;
            end else begin
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = $urandom;
            end
        end
        check("stall_cycles", stall_cnt, fin + 1);
        i_req_valid  = 1'b0;
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
    endtask

    initial begin
        int rv_seen;

        rst_n        = 1'b0;
        held_rd      = '0;
        i_req_valid  = 1'b1;
        i_req_wr     = 1'b0;
        i_req_funct3 = 3'd2;
        i_req_addr   = 32'h40;
        i_req_wdata  = 32'h1234_5678;
        i_mem_ready  = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hDEAD_BEEF;
        #2;
        check("reset_outputs_zero",
              {o_stall, o_rd_valid, o_fault, o_timeout, o_mem_valid, o_mem_wr, o_mem_strb},
              0);
        check("reset_rd_data", o_rd_data, 0);
        check("reset_mem_addr_wdata", {o_mem_addr, o_mem_wdata}, 0);
        i_req_valid  = 1'b0;
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Byte store into the top lane, two wait cycles before ready.
        do_txn(1'b1, 3'd0, 32'h103, 32'h0000_00AB, 32'h0, 2, 0);
        // Signed and unsigned halfword loads from lane 2.
        do_txn(1'b0, 3'd1, 32'h202, 32'h0, 32'h8001_1234, 0, 1);
        do_txn(1'b0, 3'd5, 32'h202, 32'h0, 32'h8001_1234, 1, 0);
        // Misaligned word load.
        do_txn(1'b0, 3'd2, 32'h006, 32'h0, 32'h0, 0, 0);
        // Doubleword and WU are illegal at this width; funct3 111 always.
        do_txn(1'b0, 3'd3, 32'h010, 32'h0, 32'h0, 0, 0);
        do_txn(1'b0, 3'd6, 32'h010, 32'h0, 32'h0, 0, 0);
        do_txn(1'b1, 3'd7, 32'h010, 32'h0, 32'h0, 0, 0);
        // Word load whose request is never accepted: abort, rd_data held.
        do_txn(1'b0, 3'd2, 32'h300, 32'h0, 32'h5555_AAAA, 10, 0);
        // Load accepted on the last allowed cycle, store accepted on it.
        do_txn(1'b0, 3'd2, 32'h304, 32'h0, 32'h1111_2222, 3, 0);
        do_txn(1'b1, 3'd1, 32'h306, 32'hCAFE_F00D, 32'h0, 3, 0);
        // Load that runs out of budget while waiting for data.
        do_txn(1'b0, 3'd0, 32'h309, 32'h0, 32'h0000_8000, 1, 2);

        // Reset during WAIT abandons the load; a later rvalid is discarded.
        do_txn(1'b0, 3'd4, 32'h401, 32'h0, 32'h0000_7F00, 0, 0);
        i_req_valid  = 1'b1;
        i_req_wr     = 1'b0;
        i_req_funct3 = 3'd2;
        i_req_addr   = 32'h500;
        e_push_reset_req();
        @(posedge clk);
        #1;
        i_mem_ready = 1'b1;
        @(posedge clk);
        #1;
        i_mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        held_rd = '0;
        #1;
        check("midreset_outputs_zero",
              {o_stall, o_rd_valid, o_fault, o_timeout, o_mem_valid, o_mem_wr, o_mem_strb},
              0);
        check("midreset_rd_data", o_rd_data, 0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        i_req_valid  = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h7777_7777;
        rv_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_rd_valid || o_stall) rv_seen++;
            @(posedge clk);
            #1;
            i_mem_rvalid = 1'b0;
        end
        check("post_reset_quiet", rv_seen, 0);
        check("post_reset_rd_data", o_rd_data, 0);

        // Back-to-back load then store.
        do_txn(1'b0, 3'd2, 32'h600, 32'h0, 32'h89AB_CDEF, 0, 0);
        do_txn(1'b1, 3'd2, 32'h604, 32'h0246_8ACE, 32'h0, 0, 0);

        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'h0000_0FF0) | 32'($urandom_range(0, 3));
            do_txn(1'($urandom % 2), 3'($urandom % 8), a, $urandom, $urandom,
                   $urandom_range(0, 4), $urandom_range(0, 2));
        end

        repeat (4) @(posedge clk);
        #1;
        check("q_mem_drained", q_mem.size(), 0);
        check("q_rd_drained", q_rd.size(), 0);
        check("q_fault_drained", q_fault.size(), 0);
        check("q_to_drained", q_to.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // The abandoned load is still handshaken before the reset hits.
    task automatic e_push_reset_req();
        mem_exp_t e;
        e.addr  = 32'h500;
        e.wr    = 1'b0;
        e.wdata = 32'h0;
        e.strb  = 4'h0;
        q_mem.push_back(e);
    endtask

endmodule
